st7735_spi_receiver: RTL and testbench

ST7735_SPI_RECEIVER -- requirements
Module: st7735_spi_receiver

---
 rtl/st7735_spi_receiver_if.sv | 31 +++
 rtl/st7735_spi_receiver.sv | 192 +++++++++++++++++++
 tb/tb_st7735_spi_receiver.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/st7735_spi_receiver_if.sv
// Bundle of the ST7735 panel-side SPI pins and the receive-side consumer
// handshake, so that the receiver and its environment share one port.
interface st7735_spi_receiver_if;
  logic       CS;
  logic       MOSI;
  logic       DC;
  logic       LCD_CLK;
  logic       LCD_RESET_N;
  logic [7:0] RX_DATA;
  logic       RX_IS_DATA;
  logic       RX_VALID;
  logic       RX_READY;
  logic [7:0] LAST_CMD;
  logic [7:0] PARAM_IDX;
  logic       BUSY;
  logic       OVERFLOW;
  logic       FRAME_ERR;
  logic       CLR_FLAGS;

  modport master (
    output CS, MOSI, DC, LCD_CLK, LCD_RESET_N, RX_READY, CLR_FLAGS,
    input  RX_DATA, RX_IS_DATA, RX_VALID, LAST_CMD, PARAM_IDX,
           BUSY, OVERFLOW, FRAME_ERR
  );

  modport slave (
    input  CS, MOSI, DC, LCD_CLK, LCD_RESET_N, RX_READY, CLR_FLAGS,
    output RX_DATA, RX_IS_DATA, RX_VALID, LAST_CMD, PARAM_IDX,
           BUSY, OVERFLOW, FRAME_ERR
  );
endinterface

// File: rtl/st7735_spi_receiver.sv
// SPI (mode 0) byte receiver for an ST7735-style panel link. The SPI pins are
// oversampled by SYSTEM_CLK through synchronizers; completed bytes are tagged
// with DC and queued in a small FIFO, with command/parameter tracking and
// sticky overflow / framing error flags.
module st7735_spi_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input logic                  SYSTEM_CLK,
  input logic                  RST,
  st7735_spi_receiver_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(SYNC_STAGES + 1);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [SYNC_STAGES-1:0] cs_sync_q, mosi_sync_q, dc_sync_q, clk_sync_q, lrst_sync_q;
  logic                   cs_s, mosi_s, dc_s, clk_s, lrst_s;
  logic                   clk_prev_q, clk_edge;
  logic [WW-1:0]          warm_q;
  logic                   armed_q;
  logic [0:0]             state_q, state_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [6:0]             shreg_q, shreg_d;
  logic                   byte_done, frame_err_set;
  logic [7:0]             new_byte;
  logic [8:0]             mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            cnt_q;
  logic                   fifo_empty, fifo_full, pop, push_ok, overflow_set;
  logic [8:0]             head;
  logic [7:0]             last_cmd_q, param_idx_q;
  logic                   overflow_q, frame_err_q;

  // Input synchronizers, reset to the idle levels of the panel link
  always_ff @(posedge SYSTEM_CLK) begin
    if (RST) begin
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      dc_sync_q   <= '0;
      clk_sync_q  <= '0;
      lrst_sync_q <= '1;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   bus.CS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0],   bus.DC};
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0],  bus.LCD_CLK};
      lrst_sync_q <= {lrst_sync_q[SYNC_STAGES-2:0], bus.LCD_RESET_N};
    end
  end

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign dc_s     = dc_sync_q[SYNC_STAGES-1];
  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign lrst_s   = lrst_sync_q[SYNC_STAGES-1];
  assign clk_edge = clk_s & ~clk_prev_q;
  assign new_byte = {shreg_q, mosi_s};

  // Edge-detect history, plus arming: after RST the CS chain holds its reset
  // value until refilled, so a frame may only start once CS has been seen high
  // through a fully refilled chain (a frame cut by RST resumes on a real CS fall)
  always_ff @(posedge SYSTEM_CLK) begin
    if (RST) begin
      clk_prev_q <= 1'b0;
      warm_q     <= '0;
      armed_q    <= 1'b0;
    end else begin
      clk_prev_q <= clk_s;
      if (warm_q != WW'(SYNC_STAGES)) warm_q <= warm_q + WW'(1);
      if (warm_q == WW'(SYNC_STAGES) && cs_s) armed_q <= 1'b1;
    end
  end

  // Frame FSM and bit assembly; panel reset aborts silently
  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    shreg_d       = shreg_q;
    byte_done     = 1'b0;
    frame_err_set = 1'b0;
    if (!lrst_s) begin
      state_d  = ST_IDLE;
      bitcnt_d = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!cs_s && armed_q) begin
            state_d  = ST_SHIFT;
            bitcnt_d = 3'd0;
            shreg_d  = 7'd0;
          end
        end
        ST_SHIFT: begin
          if (cs_s) begin
            state_d       = ST_IDLE;
            frame_err_set = (bitcnt_q != 3'd0);
            bitcnt_d      = 3'd0;
          end else if (clk_edge) begin
            shreg_d   = {shreg_q[5:0], mosi_s};
            bitcnt_d  = bitcnt_q + 3'd1;
            byte_done = (bitcnt_q == 3'd7);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state registers
  always_ff @(posedge SYSTEM_CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= 3'd0;
      shreg_q  <= 7'd0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
    end
  end

  assign fifo_empty   = (cnt_q == '0);
  assign fifo_full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop          = !fifo_empty && bus.RX_READY;
  assign push_ok      = byte_done && (!fifo_full || pop);
  assign overflow_set = byte_done && fifo_full && !pop;

  // FIFO storage; contents are qualified by the count, so no reset needed
  always_ff @(posedge SYSTEM_CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= {dc_s, new_byte};
  end

  // FIFO pointers and occupancy; panel reset flushes
  always_ff @(posedge SYSTEM_CLK) begin
    if (RST || !lrst_s) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (pop && !push_ok) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  // Command / parameter tracking, updated even when the FIFO drops the byte
  always_ff @(posedge SYSTEM_CLK) begin
    if (RST || !lrst_s) begin
      last_cmd_q  <= 8'h00;
      param_idx_q <= 8'h00;
    end else if (byte_done) begin
      if (!dc_s) begin
        last_cmd_q  <= new_byte;
        param_idx_q <= 8'h00;
      end else begin
        param_idx_q <= sat_inc8(param_idx_q);
      end
    end
  end

  // Sticky error flags; a set event beats a simultaneous clear
  always_ff @(posedge SYSTEM_CLK) begin
    if (RST) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (overflow_set)       overflow_q <= 1'b1;
      else if (bus.CLR_FLAGS) overflow_q <= 1'b0;
      if (frame_err_set)      frame_err_q <= 1'b1;
      else if (bus.CLR_FLAGS) frame_err_q <= 1'b0;
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign bus.RX_VALID   = !fifo_empty;
  assign bus.RX_DATA    = fifo_empty ? 8'h00 : head[7:0];
  assign bus.RX_IS_DATA = fifo_empty ? 1'b0  : head[8];
  assign bus.LAST_CMD   = last_cmd_q;
  assign bus.PARAM_IDX  = param_idx_q;
  assign bus.BUSY       = ~cs_s;
  assign bus.OVERFLOW   = overflow_q;
  assign bus.FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_st7735_spi_receiver.sv
// Bench for st7735_spi_receiver: random SPI traffic with a queue-based
// reference model and an independent monitor that checks every FIFO beat.
module tb_st7735_spi_receiver;
  localparam int SYNC  = 2;
  localparam int DEPTH = 4;
  localparam int HALF  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  st7735_spi_receiver_if bus();

  st7735_spi_receiver #(.SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH)) dut (
    .SYSTEM_CLK(clk),
    .RST       (rst),
    .bus       (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [8:0] exp_q[$];
  logic [7:0] m_last, m_param;
  bit         m_ovf, m_ferr, m_rx_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input logic dc);
    if (!m_rx_en) return;
    if (exp_q.size() < DEPTH) exp_q.push_back({dc, b});
    else m_ovf = 1'b1;
    if (!dc) begin
      m_last  = b;
      m_param = 8'd0;
    end else if (m_param != 8'd255) begin
      m_param = m_param + 8'd1;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_last  = 8'd0;
    m_param = 8'd0;
    m_ovf   = 1'b0;
    m_ferr  = 1'b0;
  endtask

  // Shift nbits of b (MSB first); meas checks push latency after the 8th edge
  task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits, input bit meas);
    bit seen;
    for (int i = 0; i < nbits; i++) begin
      bus.MOSI    = b[7-i];
      bus.DC      = dc;
      bus.LCD_CLK = 1'b0;
      cyc(HALF);
      bus.LCD_CLK = 1'b1;
      if (i == 7) model_byte(b, dc);
      if (i == 7 && meas) begin
        seen = 1'b0;
        for (int k = 1; k <= SYNC + 2; k++) begin
          @(posedge clk);
          #1;
          if (bus.RX_VALID) begin
            seen = 1'b1;
            break;
          end
        end
        #1;
        chk("push_latency", 32'(seen), 32'd1);
        cyc(1);
      end else begin
        cyc(HALF);
      end
    end
    bus.LCD_CLK = 1'b0;
    cyc(HALF);
  endtask

  task automatic cs_low();
    bus.CS  = 1'b0;
    m_rx_en = 1'b1;
    cyc(4);
  endtask

  task automatic cs_high();
    bus.CS = 1'b1;
    cyc(6);
  endtask

  task automatic pulse_clr();
    bus.CLR_FLAGS = 1'b1;
    cyc(1);
    bus.CLR_FLAGS = 1'b0;
    cyc(1);
  endtask

  task automatic chk_track(input string tag);
    chk({tag, "_last_cmd"},  32'(bus.LAST_CMD),  32'(m_last));
    chk({tag, "_param_idx"}, 32'(bus.PARAM_IDX), 32'(m_param));
  endtask

  // Monitor: every accepted beat must match the head of the expected queue
  always @(negedge clk) begin : mon
    logic [8:0] e;
    if (!rst && bus.RX_VALID && bus.RX_READY) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat: got %0h expected none", {bus.RX_IS_DATA, bus.RX_DATA});
      end else begin
        e = exp_q.pop_front();
        chk("rx_beat", 32'({bus.RX_IS_DATA, bus.RX_DATA}), 32'(e));
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic       d;
    int         n;
    bus.CS = 1'b1; bus.MOSI = 1'b0; bus.DC = 1'b0; bus.LCD_CLK = 1'b0;
    bus.LCD_RESET_N = 1'b1; bus.RX_READY = 1'b1; bus.CLR_FLAGS = 1'b0;
    m_rx_en = 1'b1;
    model_reset();

    // Reset state
    rst = 1'b1;
    cyc(3);
    chk("rst_rx_valid",   32'(bus.RX_VALID),   32'd0);
    chk("rst_rx_data",    32'(bus.RX_DATA),    32'd0);
    chk("rst_rx_is_data", 32'(bus.RX_IS_DATA), 32'd0);
    chk("rst_last_cmd",   32'(bus.LAST_CMD),   32'd0);
    chk("rst_param_idx",  32'(bus.PARAM_IDX),  32'd0);
    chk("rst_busy",       32'(bus.BUSY),       32'd0);
    chk("rst_overflow",   32'(bus.OVERFLOW),   32'd0);
    chk("rst_frame_err",  32'(bus.FRAME_ERR),  32'd0);
    rst = 1'b0;
    cyc(6);

    // Single command byte, with push latency
    cs_low();
    chk("busy_in_frame", 32'(bus.BUSY), 32'd1);
    send_bits(8'h2C, 1'b0, 8, 1'b1);
    cs_high();
    chk("busy_after_frame", 32'(bus.BUSY), 32'd0);
    chk("cmd_last_cmd", 32'(bus.LAST_CMD), 32'h2C);
    chk_track("cmd");

    // Command followed by four parameters in one frame
    cs_low();
    send_bits(8'h2A, 1'b0, 8, 1'b0);
    send_bits(8'h00, 1'b1, 8, 1'b0);
    send_bits(8'h00, 1'b1, 8, 1'b0);
    send_bits(8'h00, 1'b1, 8, 1'b0);
    send_bits(8'h7F, 1'b1, 8, 1'b0);
    cs_high();
    chk("caset_param_idx", 32'(bus.PARAM_IDX), 32'd4);
    chk_track("caset");

    // Overflow with the consumer stalled
    cs_low();
    send_bits(8'($urandom_range(255)), 1'b0, 8, 1'b0);
    cyc(10);
    bus.RX_READY = 1'b0;
    for (int i = 0; i < 6; i++) send_bits(8'($urandom_range(255)), 1'b1, 8, 1'b0);
    cs_high();
    chk("ovf_flag", 32'(bus.OVERFLOW), 32'(m_ovf));
    chk("ovf_param_idx", 32'(bus.PARAM_IDX), 32'd6);
    chk("ovf_valid", 32'(bus.RX_VALID), 32'd1);
    chk("ovf_head", 32'(bus.RX_DATA), 32'(exp_q[0][7:0]));
    cyc(3);
    chk("ovf_head_stable", 32'(bus.RX_DATA), 32'(exp_q[0][7:0]));
    bus.RX_READY = 1'b1;
    cyc(10);
    chk("ovf_drained", 32'(exp_q.size()), 32'd0);
    pulse_clr();
    m_ovf = 1'b0;
    chk("ovf_cleared", 32'(bus.OVERFLOW), 32'(m_ovf));

    // Truncated frame then a clean byte
    cs_low();
    send_bits(8'($urandom_range(255)), 1'b1, 5, 1'b0);
    cs_high();
    m_ferr = 1'b1;
    chk("ferr_set", 32'(bus.FRAME_ERR), 32'(m_ferr));
    cs_low();
    send_bits(8'hA5, 1'b1, 8, 1'b0);
    cs_high();
    chk_track("ferr");

    // Panel reset with queued bytes and a partial byte
    bus.RX_READY = 1'b0;
    cs_low();
    send_bits(8'($urandom_range(255)), 1'b1, 8, 1'b0);
    send_bits(8'($urandom_range(255)), 1'b1, 8, 1'b0);
    send_bits(8'($urandom_range(255)), 1'b1, 3, 1'b0);
    bus.LCD_RESET_N = 1'b0;
    exp_q.delete();
    m_last  = 8'd0;
    m_param = 8'd0;
    cyc(10);
    chk("lrst_valid", 32'(bus.RX_VALID), 32'd0);
    chk_track("lrst");
    chk("lrst_ferr_kept", 32'(bus.FRAME_ERR), 32'(m_ferr));
    bus.LCD_RESET_N = 1'b1;
    cyc(4);
    pulse_clr();
    m_ferr = 1'b0;
    cs_high();
    chk("lrst_no_ferr", 32'(bus.FRAME_ERR), 32'(m_ferr));
    bus.RX_READY = 1'b1;

    // RST in the middle of a byte; bytes before the next CS fall are ignored
    cs_low();
    send_bits(8'($urandom_range(255)), 1'b1, 4, 1'b0);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    model_reset();
    m_rx_en = 1'b0;
    chk("rstmid_no_ferr", 32'(bus.FRAME_ERR), 32'd0);
    cyc(6);
    send_bits(8'($urandom_range(255)), 1'b0, 8, 1'b0);
    chk_track("rstmid_ignored");
    cs_high();
    cs_low();
    send_bits(8'h5A, 1'b0, 8, 1'b0);
    cs_high();
    chk_track("rstmid_resume");

    // PARAM_IDX saturation
    cs_low();
    send_bits(8'($urandom_range(255)), 1'b0, 8, 1'b0);
    for (int i = 0; i < 300; i++) begin
      send_bits(8'($urandom_range(255)), 1'b1, 8, 1'b0);
      if (i == 254) chk("sat_at_255", 32'(bus.PARAM_IDX), 32'd255);
    end
    cs_high();
    chk("sat_final", 32'(bus.PARAM_IDX), 32'd255);
    chk_track("sat");

    // Random frames
    for (int f = 0; f < 15; f++) begin
      n = $urandom_range(4, 1);
      cs_low();
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom_range(255));
        d = 1'($urandom_range(1));
        send_bits(b, d, 8, 1'b0);
      end
      cs_high();
      cyc($urandom_range(5));
      chk_track("rand");
    end

    // Drain and final flags
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) cyc(1);
    chk("final_drain", 32'(exp_q.size()), 32'd0);
    chk("final_overflow", 32'(bus.OVERFLOW), 32'(m_ovf));
    chk("final_frame_err", 32'(bus.FRAME_ERR), 32'(m_ferr));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
